// File: rtl/pixel_color_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_color_gen
// Brief    : Glyph bit + 8-bit attribute -> RGB through a fixed 16-entry
//            palette, with frame-counted cursor blink (block/underline) and a
//            fixed 2-cycle pipeline. Optional text blink: PIXEL_COLOR_BLINK_ATTR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_color_gen #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 13,
    parameter int COLOR_W      = 10,
    parameter int CELL_H       = 16,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start_i,
    input  logic               pix_valid_i,
    input  logic               pixel_bit_i,
    input  logic [ADDR_W-1:0]  char_addr_i,
    input  logic [7:0]         attr_i,
    input  logic [3:0]         glyph_row_i,
    input  logic               cursor_en_i,
    input  logic               cursor_mode_i,
    input  logic [7:0]         cursor_row_i,
    input  logic [7:0]         cursor_col_i,
    output logic [COLOR_W-1:0] color_R_o,
    output logic [COLOR_W-1:0] color_G_o,
    output logic [COLOR_W-1:0] color_B_o,
    output logic               pix_valid_o
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   c_cnt_max = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [COLOR_W-1:0] c_full    = '1;
    localparam logic [COLOR_W-1:0] c_half    = c_full >> 1;
    localparam logic [COLOR_W-1:0] c_quarter = c_full >> 2;

    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_blink_phase;

    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_cur_in_grid;
    logic              w_shape;
    logic              w_hit;

    logic              r1_valid;
    logic              r1_bit;
    logic [6:0]        r1_attr;
    logic              r1_hit;

    logic              w_fg_bit;
    logic              w_sel;
    logic [3:0]        w_idx;
    logic [COLOR_W-1:0] w_r;
    logic [COLOR_W-1:0] w_g;
    logic [COLOR_W-1:0] w_b;

    function automatic logic [COLOR_W-1:0] pal_comp(input logic b, input logic i);
        logic [COLOR_W-1:0] v;
        case ({b, i})
            2'b11:   v = c_full;
            2'b10:   v = c_half;
            2'b01:   v = c_quarter;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Blink generator: phase toggles each time the frame counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (frame_start_i) begin
            if (r_frame_cnt == c_cnt_max) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_cur_addr    = ADDR_W'(cursor_row_i) * ADDR_W'(COLS) + ADDR_W'(cursor_col_i);
        w_cur_in_grid = (32'(cursor_row_i) < 32'(ROWS)) && (32'(cursor_col_i) < 32'(COLS));
        w_shape       = ~cursor_mode_i | (32'(glyph_row_i) >= 32'(CELL_H - 2));
        w_hit         = cursor_en_i & r_blink_phase & w_cur_in_grid &
                        (w_cur_addr == char_addr_i) & w_shape;
    end

    // Stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_bit   <= 1'b0;
            r1_attr  <= '0;
            r1_hit   <= 1'b0;
        end else begin
            r1_valid <= pix_valid_i;
            r1_bit   <= pixel_bit_i;
            r1_attr  <= attr_i[6:0];
            r1_hit   <= w_hit;
        end
    end

`ifdef PIXEL_COLOR_BLINK_ATTR_EN
    logic r1_blink_attr;
    logic r1_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_blink_attr <= 1'b0;
            r1_phase      <= 1'b1;
        end else begin
            r1_blink_attr <= attr_i[7];
            r1_phase      <= r_blink_phase;
        end
    end

    // Blinking text hides the glyph during the hidden phase; cursor still XORs on top.
    assign w_fg_bit = r1_bit & ~(r1_blink_attr & ~r1_phase);
`else
    logic w_unused_attr7;
    assign w_unused_attr7 = attr_i[7];
    assign w_fg_bit       = r1_bit;
`endif

    always_comb begin
        w_sel = w_fg_bit ^ r1_hit;
        w_idx = w_sel ? r1_attr[3:0] : {1'b0, r1_attr[6:4]};
        w_r   = '0;
        w_g   = '0;
        w_b   = '0;
        if (r1_valid) begin
            w_r = pal_comp(w_idx[2], w_idx[3]);
            w_g = pal_comp(w_idx[1], w_idx[3]);
            w_b = pal_comp(w_idx[0], w_idx[3]);
        end
    end

    // Stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_R_o   <= '0;
            color_G_o   <= '0;
            color_B_o   <= '0;
            pix_valid_o <= 1'b0;
        end else begin
            color_R_o   <= w_r;
            color_G_o   <= w_g;
            color_B_o   <= w_b;
            pix_valid_o <= r1_valid;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_color_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_color_gen
// Brief    : Scoreboard bench for pixel_color_gen (BLINK_FRAMES = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_color_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start_i;
    logic        pix_valid_i;
    logic        pixel_bit_i;
    logic [12:0] char_addr_i;
    logic [7:0]  attr_i;
    logic [3:0]  glyph_row_i;
    logic        cursor_en_i;
    logic        cursor_mode_i;
    logic [7:0]  cursor_row_i;
    logic [7:0]  cursor_col_i;
    logic [9:0]  color_R_o;
    logic [9:0]  color_G_o;
    logic [9:0]  color_B_o;
    logic        pix_valid_o;

    typedef struct {
        int         id;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pixel_color_gen #(
        .COLS(80), .ROWS(30), .ADDR_W(13), .COLOR_W(10), .CELL_H(16), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_start_i(frame_start_i), .pix_valid_i(pix_valid_i),
        .pixel_bit_i(pixel_bit_i), .char_addr_i(char_addr_i), .attr_i(attr_i),
        .glyph_row_i(glyph_row_i), .cursor_en_i(cursor_en_i), .cursor_mode_i(cursor_mode_i),
        .cursor_row_i(cursor_row_i), .cursor_col_i(cursor_col_i),
        .color_R_o(color_R_o), .color_G_o(color_G_o), .color_B_o(color_B_o),
        .pix_valid_o(pix_valid_o)
    );

    always #5 clk = ~clk;

    // Monitor: valid outputs are matched against the scoreboard, idle outputs must be black.
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got RGB %h/%h/%h, expected no output",
                             color_R_o, color_G_o, color_B_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (color_R_o !== e.r || color_G_o !== e.g || color_B_o !== e.b) begin
                        errors++;
                        $display("FAIL pixel_%0d got RGB %h/%h/%h, expected %h/%h/%h",
                                 e.id, color_R_o, color_G_o, color_B_o, e.r, e.g, e.b);
                    end
                end
            end else begin
                checks++;
                if (color_R_o !== 10'h0 || color_G_o !== 10'h0 || color_B_o !== 10'h0) begin
                    errors++;
                    $display("FAIL idle_black got RGB %h/%h/%h, expected 000/000/000",
                             color_R_o, color_G_o, color_B_o);
                end
            end
        end
    end

    task automatic px(input logic v, input logic b, input logic [12:0] a, input logic [7:0] at,
                      input logic [3:0] gr, input logic fs,
                      input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb,
                      input int id);
        pix_valid_i   = v;
        pixel_bit_i   = b;
        char_addr_i   = a;
        attr_i        = at;
        glyph_row_i   = gr;
        frame_start_i = fs;
        if (v) q.push_back('{id, er, eg, eb});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b1, 13'd0, 8'h0F, 4'd0, 1'b0, 10'h0, 10'h0, 10'h0, 0);
    endtask

    task automatic frame_pulse();
        px(1'b0, 1'b0, 13'd0, 8'h00, 4'd0, 1'b1, 10'h0, 10'h0, 10'h0, 0);
        px(1'b0, 1'b0, 13'd0, 8'h00, 4'd0, 1'b0, 10'h0, 10'h0, 10'h0, 0);
    endtask

    task automatic check_now(input string name, input logic [30:0] got, input logic [30:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start_i = 0; pix_valid_i = 0; pixel_bit_i = 0; char_addr_i = '0;
        attr_i = '0; glyph_row_i = '0; cursor_en_i = 0; cursor_mode_i = 0;
        cursor_row_i = 8'd2; cursor_col_i = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_state", {color_R_o, color_G_o, color_B_o, pix_valid_o}, 31'h0);
        rst = 1'b0;

        // Basic palette
        px(1, 1, 13'd0, 8'h0F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 1);
        px(1, 0, 13'd1, 8'h0F, 4'd0, 0, 10'h000, 10'h000, 10'h000, 2);
        px(1, 1, 13'd2, 8'h04, 4'd0, 0, 10'h1FF, 10'h000, 10'h000, 3);
        px(1, 1, 13'd3, 8'h08, 4'd0, 0, 10'h0FF, 10'h0FF, 10'h0FF, 4);
        px(1, 0, 13'd4, 8'h3A, 4'd0, 0, 10'h000, 10'h1FF, 10'h1FF, 5);
        px(1, 1, 13'd5, 8'h3A, 4'd0, 0, 10'h0FF, 10'h3FF, 10'h0FF, 6);
        px(0, 1, 13'd6, 8'h0F, 4'd0, 0, 10'h000, 10'h000, 10'h000, 0);

        // Block cursor at (2,5) = 165
        cursor_en_i = 1; cursor_mode_i = 0;
        px(1, 0, 13'd164, 8'h1F, 4'd0, 0, 10'h000, 10'h000, 10'h1FF, 10);
        px(1, 0, 13'd165, 8'h1F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 11);
        px(1, 0, 13'd166, 8'h1F, 4'd0, 0, 10'h000, 10'h000, 10'h1FF, 12);
        px(1, 1, 13'd165, 8'h1F, 4'd3, 0, 10'h000, 10'h000, 10'h1FF, 13);

        // Underline cursor
        cursor_mode_i = 1;
        px(1, 0, 13'd165, 8'h1F, 4'd13, 0, 10'h000, 10'h000, 10'h1FF, 20);
        px(1, 0, 13'd165, 8'h1F, 4'd14, 0, 10'h3FF, 10'h3FF, 10'h3FF, 21);
        px(1, 0, 13'd165, 8'h1F, 4'd15, 0, 10'h3FF, 10'h3FF, 10'h3FF, 22);
        px(1, 0, 13'd164, 8'h1F, 4'd15, 0, 10'h000, 10'h000, 10'h1FF, 23);
        cursor_mode_i = 0;

        // Blink: two frames hide the cursor, wrap pixel uses old phase
        frame_pulse();
        frame_pulse();
        px(1, 0, 13'd165, 8'h1F, 4'd0, 0, 10'h000, 10'h000, 10'h1FF, 30);
        frame_pulse();
        px(1, 0, 13'd165, 8'h1F, 4'd0, 1, 10'h000, 10'h000, 10'h1FF, 31);
        px(1, 0, 13'd165, 8'h1F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 32);

        // Out-of-grid cursor: col 80 aliases to address 240, row 30 to 2400
        cursor_col_i = 8'd80;
        px(1, 0, 13'd240, 8'h1F, 4'd0, 0, 10'h000, 10'h000, 10'h1FF, 40);
        cursor_col_i = 8'd0; cursor_row_i = 8'd30;
        px(1, 0, 13'd2400, 8'h1F, 4'd0, 0, 10'h000, 10'h000, 10'h1FF, 41);
        cursor_row_i = 8'd2; cursor_col_i = 8'd5;

        // Attribute blink
        cursor_en_i = 0;
        px(1, 1, 13'd10, 8'h8F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 50);
        frame_pulse();
        frame_pulse();
`ifdef PIXEL_COLOR_BLINK_ATTR_EN
        px(1, 1, 13'd10, 8'h8F, 4'd0, 0, 10'h000, 10'h000, 10'h000, 51);
`else
        px(1, 1, 13'd10, 8'h8F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 51);
`endif
        px(1, 1, 13'd11, 8'h0F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 52);

        // Async reset mid-stream (blink currently hidden)
        cursor_en_i = 1;
        px(1, 1, 13'd0, 8'h0F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 60);
        px(1, 1, 13'd0, 8'h0F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 61);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset_outputs", {color_R_o, color_G_o, color_B_o, pix_valid_o}, 31'h0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        px(1, 0, 13'd165, 8'h1F, 4'd0, 0, 10'h3FF, 10'h3FF, 10'h3FF, 62);
        check_now("refill_cycle1_valid", {30'h0, pix_valid_o}, 31'h0);
        pix_valid_i = 0;
        @(posedge clk);
        #1;
        check_now("refill_cycle2_valid", {30'h0, pix_valid_o}, 31'h1);

        idle(4);
        check_now("scoreboard_drained", 31'(q.size()), 31'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_color_gen.md
# pixel_color_gen

Parametrised successor to the monochrome pixel colour stage of the VGA text controller. Converts a font glyph bit plus an 8-bit character attribute into COLOR_W-bit RGB through a fixed 16-entry palette. Generates its own frame-counted cursor blink and supports block and underline cursors on a COLS×ROWS text grid. Sits between the font ROM/attribute fetch and the VGA DAC outputs, with a fixed 2-cycle pipeline.

## Interface
- COLS, 80: text columns per row
- ROWS, 30: text rows
- ADDR_W, 13: char_addr_i width; must satisfy COLS*ROWS <= 2^ADDR_W
- COLOR_W, 10: bits per colour component
- CELL_H, 16: scanlines per character cell
- BLINK_FRAMES, 16: frames per blink half-period (>= 1)

- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_start_i  in  1  one-cycle pulse per frame (vsync)
- pix_valid_i  in  1  pixel is inside the active area
- pixel_bit_i  in  1  glyph bit (1 = foreground)
- char_addr_i  in  ADDR_W  linear cell address of the current pixel
- attr_i  in  8  [3:0] fg index, [6:4] bg index, [7] blink
- glyph_row_i  in  4  scanline within the cell, 0..CELL_H-1
- cursor_en_i  in  1  cursor enable
- cursor_mode_i  in  1  0 = block, 1 = underline
- cursor_row_i  in  8  cursor row
- cursor_col_i  in  8  cursor column
- color_R_o / color_G_o / color_B_o  out  COLOR_W each  pixel colour
- pix_valid_o  out  1  pix_valid_i delayed by 2 cycles

## Operation
- Blink generator:
  - frame counter 0..BLINK_FRAMES-1 increments on each frame_start_i.
  - On wrap to 0, blink_phase toggles.
  - Reset: counter = 0, blink_phase = 1 (visible).
- Cursor address: cursor_row_i*COLS + cursor_col_i, ADDR_W bits.
  - The cursor is suppressed if cursor_row_i >= ROWS or cursor_col_i >= COLS.
- Cursor hit:
  - Conditions: cursor_en_i & blink_phase & address match & shape.
  - Shape: block = always; underline = glyph_row_i >= CELL_H-2.
- Colour select:
  - sel = pixel_bit_i XOR hit.
  - sel = 1 → fg index; sel = 0 → bg index, zero-extended to 4 bits.
- Palette: index bit0 = B, bit1 = G, bit2 = R, bit3 = I. Per component:
  - bit set, I = 1 → all-ones
  - bit set, I = 0 → all-ones >> 1
  - bit clear, I = 1 → all-ones >> 2
  - bit clear, I = 0 → 0
- pix_valid_i = 0 forces an RGB of 0 at the output, regardless of the other inputs.

## Timing
- Stage 1 (edge 1) registers:
  - pix_valid, pixel bit, attr
  - cursor-hit flag; the cursor address comparison is combinational before this edge
  - blink_phase sample
- Stage 2 (edge 2) registers the palette output into color_*_o and pix_valid_o.
- Latency is exactly 2 cycles, with no stalls; a new pixel is accepted every cycle.
- Reset clears both pipeline stages: color_*_o = 0, pix_valid_o = 0.
- Cursor inputs are sampled every cycle. A change takes effect on the pixel entering stage 1 in that same cycle.
- If frame_start_i coincides with a wrap, blink_phase toggles at that edge. Pixels entering stage 1 in the same cycle use the old phase.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). After deassertion the pipeline refills in 2 cycles, and blink restarts in the visible phase.

## Configuration
- PIXEL_COLOR_BLINK_ATTR_EN defined:
  - a cell with attr_i[7] = 1 has sel forced to 0 while blink_phase = 0, so the glyph is hidden and bg is shown.
  - The cursor hit is still applied, XOR against the forced sel.
- Undefined: attr_i[7] is ignored and no text blinking occurs. All other behaviour is identical.

## Test plan
- Reset, then valid pixels with pixel_bit_i = 1, attr = 8'h0F, COLOR_W = 10:
  - 2 cycles later RGB = 3FF/3FF/3FF and pix_valid_o = 1.
  - With pixel_bit_i = 0: RGB = 0/0/0.
- Palette: fg = 4'h4, pixel_bit_i = 1 → R = 1FF, G = 0, B = 0. fg = 4'h8 → all components = 0FF.
- Cursor at row 2, col 5 (addr 165), block mode, cursor_en_i = 1, glyph bit 0, attr 8'h1F:
  - RGB = 3FF (fg) only at char_addr 165.
  - Underline mode: inversion only for glyph_row_i 14 and 15.
- Blink, BLINK_FRAMES = 2: pulse frame_start_i 2× → cursor is not drawn; 2× more → cursor is drawn again. cursor_col_i = 80 → never drawn.
- With the macro, attr 8'h8F, glyph bit 1: bright white in the visible phase, black in the hidden phase. Without the macro: always white.
- Async rst pulse during a pixel stream: outputs are 0 within the same cycle; the first valid output appears 2 cycles after deassertion.
